// File: rtl/partition_err_sweep_ctrl.sv
// Exhaustive input sweep for one adder partition. It compares the exact and the
// approximate partition outputs and accumulates mismatch, Hamming and worst-case error metrics.
module partition_err_sweep_ctrl #(
    parameter int NIN  = 8,
    parameter int NOUT = 5,
    parameter int LAT  = 1,
    parameter int HW   = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [NIN-1:0]    pat_o,
    output logic              pat_vld_o,
    input  logic [NOUT-1:0]   exact_i,
    input  logic [NOUT-1:0]   approx_i,
    output logic [NIN:0]      mism_cnt,
    output logic [HW-1:0]     ham_sum,
    output logic [NOUT-1:0]   max_err,
    output logic [NIN-1:0]    wce_pat
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [NIN-1:0] PAT_LAST   = {NIN{1'b1}};
    localparam int             DCW        = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'((LAT > 0) ? (LAT - 1) : 0);

    state_t            state_r;
    state_t            state_nx_s;
    logic [DCW-1:0]    drain_cnt_r;
    logic [NIN-1:0]    pat_r;
    logic              busy_r;
    logic              done_r;
    logic              vld_r;
    logic              busy_nx_s;
    logic              done_nx_s;
    logic              vld_nx_s;
    logic              issue_vld_s;
    logic              flush_s;
    logic              launch_s;
    logic              samp_vld_s;
    logic [NIN-1:0]    samp_tag_s;
    logic              acc_en_s;
    logic [NOUT-1:0]   diff_s;
    logic [NOUT-1:0]   err_s;
    logic [NIN:0]      mism_r;
    logic [HW-1:0]     ham_r;
    logic [NOUT-1:0]   max_r;
    logic [NIN-1:0]    wce_r;

    // Number of set bits in a partition output difference word.
    function automatic logic [HW-1:0] popcnt(input logic [NOUT-1:0] v);
        logic [HW-1:0] acc;
        acc = {HW{1'b0}};
        for (int i = 0; i < NOUT; i++) begin
            acc = acc + {{(HW-1){1'b0}}, v[i]};
        end
        return acc;
    endfunction

    // Unsigned distance between two outputs, widened by one bit before subtracting.
    function automatic logic [NOUT:0] abs_diff(input logic [NOUT-1:0] a, input logic [NOUT-1:0] b);
        logic [NOUT:0] r;
        if (a >= b) begin
            r = {1'b0, a} - {1'b0, b};
        end else begin
            r = {1'b0, b} - {1'b0, a};
        end
        return r;
    endfunction

    assign issue_vld_s = (state_r == ST_SWEEP);
    assign flush_s     = abort && ((state_r == ST_SWEEP) || (state_r == ST_DRAIN));
    assign launch_s    = (state_r == ST_IDLE) && start;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode; abort only matters while a sweep is in flight.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s = ST_SWEEP;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (abort) begin
                    state_nx_s = ST_IDLE;
                end else if (pat_r == PAT_LAST) begin
                    state_nx_s = (LAT == 0) ? ST_DONE : ST_DRAIN;
                end else begin
                    state_nx_s = ST_SWEEP;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_nx_s = ST_IDLE;
                end else if (drain_cnt_r == DRAIN_LAST) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so that the flags come straight out of flops.
    always_comb begin
        busy_nx_s = 1'b0;
        done_nx_s = 1'b0;
        vld_nx_s  = 1'b0;
        case (state_nx_s)
            ST_SWEEP: begin
                busy_nx_s = 1'b1;
                vld_nx_s  = 1'b1;
            end
            ST_DRAIN: busy_nx_s = 1'b1;
            ST_DONE:  done_nx_s = 1'b1;
            ST_IDLE:  busy_nx_s = 1'b0;
            default:  busy_nx_s = 1'b0;
        endcase
    end

    // Registered status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            vld_r  <= 1'b0;
        end else begin
            busy_r <= busy_nx_s;
            done_r <= done_nx_s;
            vld_r  <= vld_nx_s;
        end
    end

    // The pattern counter doubles as pat_o, so it holds its last value through DRAIN and DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pat_r <= {NIN{1'b0}};
        end else if (launch_s) begin
            pat_r <= {NIN{1'b0}};
        end else if ((state_r == ST_SWEEP) && (state_nx_s == ST_SWEEP)) begin
            pat_r <= pat_r + NIN'(1);
        end else begin
            pat_r <= pat_r;
        end
    end

    // Drain cycle counter, held at zero outside DRAIN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drain_cnt_r <= {DCW{1'b0}};
        end else if (state_r == ST_DRAIN) begin
            drain_cnt_r <= drain_cnt_r + DCW'(1);
        end else begin
            drain_cnt_r <= {DCW{1'b0}};
        end
    end

    generate
        if (LAT == 0) begin : g_nopipe
            assign samp_vld_s = issue_vld_s;
            assign samp_tag_s = pat_r;
        end else begin : g_pipe
            logic [LAT-1:0] pv_r;
            logic [NIN-1:0] pt_r [LAT];

            // Tag shift register; the partition result for pt_r[LAT-1] is on the inputs now.
            always_ff @(posedge clk) begin
                if (!rst_n || flush_s) begin
                    pv_r <= {LAT{1'b0}};
                    for (int i = 0; i < LAT; i++) begin
                        pt_r[i] <= {NIN{1'b0}};
                    end
                end else begin
                    pv_r[0] <= issue_vld_s;
                    pt_r[0] <= pat_r;
                    for (int i = 1; i < LAT; i++) begin
                        pv_r[i] <= pv_r[i-1];
                        pt_r[i] <= pt_r[i-1];
                    end
                end
            end

            assign samp_vld_s = pv_r[LAT-1];
            assign samp_tag_s = pt_r[LAT-1];
        end
    endgenerate

    assign acc_en_s = samp_vld_s && !flush_s;
    assign diff_s   = exact_i ^ approx_i;
    assign err_s    = abs_diff(exact_i, approx_i)[NOUT-1:0];

    // Error accumulators; strict compare keeps the first pattern that hit the worst case.
    always_ff @(posedge clk) begin
        if (!rst_n || launch_s) begin
            mism_r <= {(NIN+1){1'b0}};
            ham_r  <= {HW{1'b0}};
            max_r  <= {NOUT{1'b0}};
            wce_r  <= {NIN{1'b0}};
        end else if (acc_en_s) begin
            mism_r <= mism_r + {{NIN{1'b0}}, (diff_s != {NOUT{1'b0}})};
            ham_r  <= ham_r + popcnt(diff_s);
            if (err_s > max_r) begin
                max_r <= err_s;
                wce_r <= samp_tag_s;
            end else begin
                max_r <= max_r;
                wce_r <= wce_r;
            end
        end else begin
            mism_r <= mism_r;
            ham_r  <= ham_r;
            max_r  <= max_r;
            wce_r  <= wce_r;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign pat_vld_o = vld_r;
    assign pat_o     = pat_r;
    assign mism_cnt  = mism_r;
    assign ham_sum   = ham_r;
    assign max_err   = max_r;
    assign wce_pat   = wce_r;

endmodule

// File: tb/tb_partition_err_sweep_ctrl.sv
// Bench for partition_err_sweep_ctrl: LAT=1 and LAT=3 instances fed by a delayed partition
// model. Expected metrics come from an arithmetic pass over the pattern range.
module tb_partition_err_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start1, abort1, start3, abort3;
    logic [4:0]  exact1, approx1, exact3, approx3;
    logic        busy1, done1, vld1, busy3, done3, vld3;
    logic [7:0]  pat1, wce1, pat3, wce3;
    logic [8:0]  mism1, mism3;
    logic [10:0] ham1, ham3;
    logic [4:0]  maxe1, maxe3;

    partition_err_sweep_ctrl #(.NIN(8), .NOUT(5), .LAT(1), .HW(11)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .busy(busy1), .done(done1), .pat_o(pat1), .pat_vld_o(vld1),
        .exact_i(exact1), .approx_i(approx1), .mism_cnt(mism1),
        .ham_sum(ham1), .max_err(maxe1), .wce_pat(wce1)
    );

    partition_err_sweep_ctrl #(.NIN(8), .NOUT(5), .LAT(3), .HW(11)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
        .busy(busy3), .done(done3), .pat_o(pat3), .pat_vld_o(vld3),
        .exact_i(exact3), .approx_i(approx3), .mism_cnt(mism3),
        .ham_sum(ham3), .max_err(maxe3), .wce_pat(wce3)
    );

    int         nchk = 0;
    int         npass = 0;
    int         mode1 = 0;
    int         mode3 = 0;
    bit         sel3 = 1'b0;
    logic [4:0] rtab [256];
    logic [7:0] h1 [4];
    logic [7:0] h3 [4];

    logic        s_busy, s_done, s_vld;
    logic [7:0]  s_pat, s_wce;
    logic [8:0]  s_mism;
    logic [10:0] s_ham;
    logic [4:0]  s_maxe;
    assign s_busy = sel3 ? busy3 : busy1;
    assign s_done = sel3 ? done3 : done1;
    assign s_vld  = sel3 ? vld3  : vld1;
    assign s_pat  = sel3 ? pat3  : pat1;
    assign s_wce  = sel3 ? wce3  : wce1;
    assign s_mism = sel3 ? mism3 : mism1;
    assign s_ham  = sel3 ? ham3  : ham1;
    assign s_maxe = sel3 ? maxe3 : maxe1;

    // Approximate partition behaviour for a given pattern under each scenario.
    function automatic logic [4:0] apx(input int mode, input logic [7:0] p);
        logic [4:0] ex;
        ex = p[4:0];
        case (mode)
            0: return ex;
            1: return 5'd0;
            2: return (p == 8'h80) ? (ex | 5'h10) : ex;
            default: return rtab[p];
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk = nchk + 1;
        assert (obs === exp) npass = npass + 1;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance one clock; the partition copies answer LAT cycles after seeing a pattern.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 3; i > 0; i--) begin
            h1[i] = h1[i-1];
            h3[i] = h3[i-1];
        end
        h1[0]   = pat1;
        h3[0]   = pat3;
        exact1  = h1[1][4:0];
        approx1 = apx(mode1, h1[1]);
        exact3  = h3[3][4:0];
        approx3 = apx(mode3, h3[3]);
    endtask

    task automatic model(input int mode, input int first, input int last,
                         output int m, output int h, output int mx, output int wp);
        int ex, ap, e;
        m = 0; h = 0; mx = 0; wp = 0;
        for (int p = first; p <= last; p++) begin
            ex = p % 32;
            ap = int'(apx(mode, 8'(p)));
            if (ex != ap) m++;
            h += $countones(ex ^ ap);
            e = (ex > ap) ? ex - ap : ap - ex;
            if (e > mx) begin
                mx = e;
                wp = p;
            end
        end
    endtask

    task automatic set_start(input logic v);
        if (sel3) start3 = v;
        else start1 = v;
    endtask

    task automatic check_metrics(input string tag, input int mode, input int first, input int last);
        int m, h, mx, wp;
        model(mode, first, last, m, h, mx, wp);
        check({tag, "_mism"}, 32'(s_mism), m);
        check({tag, "_ham"},  32'(s_ham),  h);
        check({tag, "_max"},  32'(s_maxe), mx);
        check({tag, "_wce"},  32'(s_wce),  wp);
    endtask

    task automatic run_sweep(input string tag, input int mode, input bit extra, input int lat);
        int k, nvld, ddist;
        logic busy_at_done;
        if (sel3) mode3 = mode;
        else mode1 = mode;
        set_start(1'b1);
        tick();
        set_start(1'b0);
        check({tag, "_first_vld"}, 32'(s_vld), 1);
        check({tag, "_first_pat"}, 32'(s_pat), 0);
        check({tag, "_cleared"},   32'(s_mism), 0);
        k = 0; nvld = 0; ddist = -1; busy_at_done = 1'bx;
        while (k < 2000 && ddist < 0) begin
            if (s_vld) nvld++;
            if (s_done) begin
                ddist = k;
                busy_at_done = s_busy;
            end
            set_start((extra && (k == 10 || k == 200)) ? 1'b1 : 1'b0);
            tick();
            k++;
        end
        set_start(1'b0);
        check({tag, "_nvld"}, nvld, 256);
        check({tag, "_done_dist"}, ddist, 256 + lat);
        check({tag, "_busy_at_done"}, 32'(busy_at_done), 0);
        check_metrics(tag, mode, 0, 255);
    endtask

    initial begin
        int k, ndone, nbusy, m_before;
        rst_n = 1'b0;
        start1 = 1'b0; abort1 = 1'b0; start3 = 1'b0; abort3 = 1'b0;
        exact1 = 5'd0; approx1 = 5'd0; exact3 = 5'd0; approx3 = 5'd0;
        for (int i = 0; i < 4; i++) begin
            h1[i] = 8'd0;
            h3[i] = 8'd0;
        end
        for (int i = 0; i < 256; i++) rtab[i] = 5'($urandom_range(0, 31));
        tick();
        tick();
        check("rst_busy", 32'(busy1), 0);
        check("rst_done", 32'(done1), 0);
        check("rst_vld",  32'(vld1),  0);
        check("rst_pat",  32'(pat1),  0);
        check("rst_mism", 32'(mism1), 0);
        check("rst_ham",  32'(ham1),  0);
        check("rst_max",  32'(maxe1), 0);
        check("rst_wce",  32'(wce1),  0);
        check("rst_busy3", 32'(busy3), 0);
        rst_n = 1'b1;
        tick();

        sel3 = 1'b0;
        run_sweep("zero", 0, 1'b0, 1);
        run_sweep("known", 1, 1'b0, 1);
        check("known_abs_mism", 32'(mism1), 248);
        check("known_abs_ham",  32'(ham1),  640);
        check("known_abs_wce",  32'(wce1),  32'h1F);

        sel3 = 1'b1;
        run_sweep("lat3", 2, 1'b0, 3);
        check("lat3_abs_max", 32'(maxe3), 16);
        check("lat3_abs_wce", 32'(wce3),  32'h80);

        sel3 = 1'b0;
        run_sweep("busy_start", 1, 1'b1, 1);

        // Abort in the cycle that drives pattern 100; samples up to pattern 98 are kept.
        mode1 = 1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        k = 0;
        while (pat1 != 8'd100 && k < 500) begin
            tick();
            k++;
        end
        check("abort_reach100", 32'(pat1), 100);
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        check("abort_busy", 32'(busy1), 0);
        check("abort_vld",  32'(vld1),  0);
        check_metrics("abort", 1, 0, 98);
        ndone = 0; nbusy = 0;
        for (int i = 0; i < 300; i++) begin
            if (done1) ndone++;
            if (busy1) nbusy++;
            tick();
        end
        check("abort_no_done", ndone, 0);
        check("abort_stay_idle", nbusy, 0);
        m_before = int'(mism1);
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        tick();
        check("idle_abort_noop", 32'(mism1), m_before);
        run_sweep("restart", 1, 1'b0, 1);

        run_sweep("rand1", 3, 1'b0, 1);
        sel3 = 1'b1;
        run_sweep("rand3", 3, 1'b0, 3);
        sel3 = 1'b0;

        // Synchronous reset in the cycle that drives pattern 50.
        mode1 = 1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        k = 0;
        while (pat1 != 8'd50 && k < 500) begin
            tick();
            k++;
        end
        check("rst_reach50", 32'(pat1), 50);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_busy", 32'(busy1), 0);
        check("mid_rst_done", 32'(done1), 0);
        check("mid_rst_vld",  32'(vld1),  0);
        check("mid_rst_pat",  32'(pat1),  0);
        check("mid_rst_mism", 32'(mism1), 0);
        check("mid_rst_ham",  32'(ham1),  0);
        check("mid_rst_max",  32'(maxe1), 0);
        check("mid_rst_wce",  32'(wce1),  0);
        nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy1 || vld1) nbusy++;
        end
        check("mid_rst_idle", nbusy, 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
